// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if
// Instruction-memory request/acknowledge bus between the sequencer and
// the instruction memory.
//   imem_req  : fetch request (sequencer -> memory)
//   imem_addr : fetch address, mirrors the program counter
//   imem_ack  : fetch complete, imem_data valid in the same cycle
//   imem_data : 32-bit instruction word
// Modports: master = sequencer side, slave = memory side.
interface proc_control_fsm_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/proc_control_fsm.sv
// proc_control_fsm
// Multicycle sequencer for the 8-bit processor. Fetches one 32-bit
// instruction at a time, decodes it, steps the shared phase bus through
// RF/EXE/WB, updates the PC and finally runs the OUTPUT/HALT phase.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : leaves IDLE (ignored elsewhere)
//   imem                : instruction-memory bus (master side)
//   state               : phase to register file / ALU
//   rs, rt, rd, imm     : decoded register indices and immediate low byte
//   alu_op, alu_src_imm : ALU opcode and B-operand select
//   instruction_invalid : suppresses the register-file write
//   alu_zero            : ALU result == 0, sampled in EXE
//   done                : register file finished OUTPUT
//   pc, instr_count     : program counter, saturating retired count
//   halted              : high in HALT
module proc_control_fsm (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    proc_control_fsm_if.master        imem,
    output logic [2:0]                state,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [7:0]                imm,
    output logic [2:0]                alu_op,
    output logic                      alu_src_imm,
    output logic                      instruction_invalid,
    input  logic                      alu_zero,
    input  logic                      done,
    output logic [7:0]                pc,
    output logic [15:0]               instr_count,
    output logic                      halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_RF     = 3'd2,
        S_EXE    = 3'd3,
        S_WB     = 3'd4,
        S_OUTPUT = 3'd5,
        S_IDLE   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic        req_q;
    logic        fetch_accept;

    // Decode of the incoming word, registered on the accepting fetch edge
    // so the fields are already valid in the first DECODE cycle.
    logic [4:0]  dec_rd;
    logic [2:0]  dec_alu_op;
    logic        dec_src_imm;
    logic        dec_invalid;
    logic [7:0]  pc_next_exe;

    assign fetch_accept   = (state_q == S_FETCH) && imem.imem_ack;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign state          = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (imem.imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = (instr_q == '1) ? S_OUTPUT : S_RF;
            S_RF:     state_d = S_EXE;
            S_EXE:    state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_OUTPUT: if (done) state_d = S_HALT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dec_rd      = imem.imem_data[15:11];
        dec_alu_op  = 3'd0;
        dec_src_imm = 1'b0;
        dec_invalid = 1'b0;
        case (imem.imem_data[31:26])
            6'h00: begin
                case (imem.imem_data[5:0])
                    6'h20:   dec_alu_op = 3'd0;
                    6'h22:   dec_alu_op = 3'd1;
                    6'h24:   dec_alu_op = 3'd2;
                    6'h25:   dec_alu_op = 3'd3;
                    6'h2A:   dec_alu_op = 3'd4;
                    default: dec_invalid = 1'b1;
                endcase
            end
            6'h08: begin
                dec_src_imm = 1'b1;
                dec_rd      = imem.imem_data[20:16];
            end
            6'h04, 6'h05: begin
                dec_alu_op  = 3'd1;
                dec_invalid = 1'b1;
            end
            default: dec_invalid = 1'b1;
        endcase
    end

    // Branch offset is two's complement; plain 8-bit addition wraps mod 256.
    always_comb begin
        pc_next_exe = pc + 8'd1;
        if ((instr_q[31:26] == 6'h04 &&  alu_zero) ||
            (instr_q[31:26] == 6'h05 && !alu_zero))
            pc_next_exe = pc + 8'd1 + instr_q[7:0];
        else if (instr_q[31:26] == 6'h02)
            pc_next_exe = instr_q[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q             <= '0;
            req_q               <= 1'b0;
            halted              <= 1'b0;
            pc                  <= '0;
            instr_count         <= '0;
            rs                  <= '0;
            rt                  <= '0;
            rd                  <= '0;
            imm                 <= '0;
            alu_op              <= '0;
            alu_src_imm         <= 1'b0;
            instruction_invalid <= 1'b0;
        end else begin
            req_q  <= (state_d == S_FETCH);
            halted <= (state_d == S_HALT);
            if (fetch_accept) begin
                instr_q             <= imem.imem_data;
                rs                  <= imem.imem_data[25:21];
                rt                  <= imem.imem_data[20:16];
                rd                  <= dec_rd;
                imm                 <= imem.imem_data[7:0];
                alu_op              <= dec_alu_op;
                alu_src_imm         <= dec_src_imm;
                instruction_invalid <= dec_invalid;
            end
            if (state_q == S_EXE)
                pc <= pc_next_exe;
            if (state_q == S_WB && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
module tb_proc_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        alu_zero = 1'b0;
    logic        done = 1'b0;
    logic [2:0]  state;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  imm;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic        instruction_invalid;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    logic        halted;

    int total = 0;
    int passed = 0;

    logic [31:0] mem [256];
    int          ack_delay = 0;
    int          wait_cnt;

    localparam logic [31:0] ADD_W = 32'h00221820; // add r3,r1,r2

    proc_control_fsm_if bus();

    proc_control_fsm dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .imem                (bus.master),
        .state               (state),
        .rs                  (rs),
        .rt                  (rt),
        .rd                  (rd),
        .imm                 (imm),
        .alu_op              (alu_op),
        .alu_src_imm         (alu_src_imm),
        .instruction_invalid (instruction_invalid),
        .alu_zero            (alu_zero),
        .done                (done),
        .pc                  (pc),
        .instr_count         (instr_count),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    // Memory model: ack combinationally once the request has waited ack_delay cycles.
    assign bus.imem_ack  = bus.imem_req && (wait_cnt >= ack_delay);
    assign bus.imem_data = mem[bus.imem_addr];

    always @(posedge clk or posedge reset) begin
        if (reset)                           wait_cnt <= 0;
        else if (bus.imem_req && bus.imem_ack) wait_cnt <= 0;
        else if (bus.imem_req)                wait_cnt <= wait_cnt + 1;
    end

    task automatic fill_adds();
        for (int i = 0; i < 256; i++) mem[i] = ADD_W;
    endtask

    task automatic do_reset();
        start = 1'b0;
        done  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for the WB cycle of the instruction with index n.
    task automatic wait_wb(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (state == 3'd4 && instr_count == 16'(n)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (state !== 3'd6) $display("FAIL reset_state got %0d want 6", state); else passed++;
        total++; if (pc !== 8'd0) $display("FAIL reset_pc got %0h want 0", pc); else passed++;
        total++; if (instr_count !== 16'd0) $display("FAIL reset_count got %0h want 0", instr_count); else passed++;
        total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'd0) $display("FAIL reset_imem req=%0b addr=%0h want 0/0", bus.imem_req, bus.imem_addr); else passed++;
        total++; if ({rs, rt, rd, imm, alu_op, alu_src_imm, instruction_invalid, halted} !== '0)
            $display("FAIL reset_outputs got rs=%0d rt=%0d rd=%0d imm=%0h op=%0d src=%0b inv=%0b halt=%0b want all 0",
                     rs, rt, rd, imm, alu_op, alu_src_imm, instruction_invalid, halted);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addi_halt();
        int exp_seq [9] = '{6, 0, 1, 2, 3, 4, 0, 1, 5};
        fill_adds();
        mem[0] = 32'h20040005; // addi r4,r0,5
        mem[1] = 32'hFFFFFFFF;
        ack_delay = 0;
        do_reset();
        total++; if (state !== 3'(exp_seq[0])) $display("FAIL seq[0] got %0d want %0d", state, exp_seq[0]); else passed++;
        start = 1'b1;
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            total++; if (state !== 3'(exp_seq[i])) $display("FAIL seq[%0d] got %0d want %0d", i, state, exp_seq[i]); else passed++;
            if (i == 2 || i == 5) begin
                total++; if (rd !== 5'd4 || imm !== 8'd5 || alu_src_imm !== 1'b1 || alu_op !== 3'd0 || instruction_invalid !== 1'b0)
                    $display("FAIL addi_fields[%0d] got rd=%0d imm=%0d src=%0b op=%0d inv=%0b want 4/5/1/0/0",
                             i, rd, imm, alu_src_imm, alu_op, instruction_invalid);
                else passed++;
            end
        end
        total++; if (instr_count !== 16'd1 || pc !== 8'd1) $display("FAIL addi_retire got count=%0d pc=%0d want 1/1", instr_count, pc); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++; if (state !== 3'd5 || halted !== 1'b0) $display("FAIL output_hold got state=%0d halted=%0b want 5/0", state, halted); else passed++;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total++; if (halted !== 1'b1 || state !== 3'd7) $display("FAIL halt_entry got halted=%0b state=%0d want 1/7", halted, state); else passed++;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        total++; if (halted !== 1'b1 || state !== 3'd7 || pc !== 8'd1) $display("FAIL halt_sticky got halted=%0b state=%0d pc=%0d want 1/7/1", halted, state, pc); else passed++;
    endtask

    task automatic test_ack_delay();
        fill_adds();
        ack_delay = 3;
        do_reset();
        launch();
        for (int i = 0; i < 4; i++) begin
            total++; if (state !== 3'd0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0)
                $display("FAIL delay_fetch[%0d] got state=%0d req=%0b addr=%0h want 0/1/0", i, state, bus.imem_req, bus.imem_addr);
            else passed++;
            @(negedge clk);
        end
        total++; if (state !== 3'd1 || bus.imem_req !== 1'b0) $display("FAIL delay_decode got state=%0d req=%0b want 1/0", state, bus.imem_req); else passed++;
        total++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3 || alu_op !== 3'd0 || alu_src_imm !== 1'b0 || instruction_invalid !== 1'b0)
            $display("FAIL add_fields got rs=%0d rt=%0d rd=%0d op=%0d src=%0b inv=%0b want 1/2/3/0/0/0",
                     rs, rt, rd, alu_op, alu_src_imm, instruction_invalid);
        else passed++;
        ack_delay = 0;
    endtask

    task automatic test_branch();
        bit ok;
        fill_adds();
        mem[2] = 32'h100000FE; // beq imm=-2
        alu_zero = 1'b1;
        do_reset();
        launch();
        wait_wb(2, ok);
        total++; if (!ok) $display("FAIL beq_taken_timeout got state=%0d want WB", state); else passed++;
        total++; if (pc !== 8'h01 || alu_op !== 3'd1 || instruction_invalid !== 1'b1)
            $display("FAIL beq_taken got pc=%0h op=%0d inv=%0b want 01/1/1", pc, alu_op, instruction_invalid);
        else passed++;
        alu_zero = 1'b0;
        do_reset();
        launch();
        wait_wb(2, ok);
        total++; if (!ok) $display("FAIL beq_not_taken_timeout got state=%0d want WB", state); else passed++;
        total++; if (pc !== 8'h03) $display("FAIL beq_not_taken got pc=%0h want 03", pc); else passed++;
        mem[2] = 32'h140000FE; // bne imm=-2, alu_zero still 0 -> taken
        do_reset();
        launch();
        wait_wb(2, ok);
        total++; if (!ok || pc !== 8'h01) $display("FAIL bne_taken got pc=%0h ok=%0b want 01/1", pc, ok); else passed++;
    endtask

    task automatic test_jump_wrap();
        bit ok;
        fill_adds();
        mem[255] = 32'h08000010; // j 0x10
        do_reset();
        launch();
        wait_wb(255, ok);
        total++; if (!ok || pc !== 8'h10 || instruction_invalid !== 1'b1)
            $display("FAIL jump got pc=%0h inv=%0b ok=%0b want 10/1/1", pc, instruction_invalid, ok);
        else passed++;
        mem[255] = ADD_W;
        do_reset();
        launch();
        wait_wb(255, ok);
        total++; if (!ok || pc !== 8'h00) $display("FAIL pc_wrap got pc=%0h ok=%0b want 00/1", pc, ok); else passed++;
    endtask

    task automatic test_invalid();
        fill_adds();
        mem[0] = 32'hF8000000; // opcode 0x3E
        mem[1] = 32'h00000021; // R-type, unlisted funct
        do_reset();
        launch();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (state !== 3'(i + 1) || instruction_invalid !== 1'b1)
                $display("FAIL invalid_phase[%0d] got state=%0d inv=%0b want %0d/1", i, state, instruction_invalid, i + 1);
            else passed++;
        end
        total++; if (pc !== 8'd1) $display("FAIL invalid_pc got %0h want 01", pc); else passed++;
        @(negedge clk);
        total++; if (instr_count !== 16'd1 || state !== 3'd0) $display("FAIL invalid_count got count=%0d state=%0d want 1/0", instr_count, state); else passed++;
        @(negedge clk);
        total++; if (state !== 3'd1 || instruction_invalid !== 1'b1) $display("FAIL bad_funct got state=%0d inv=%0b want 1/1", state, instruction_invalid); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        fill_adds();
        ack_delay = 0;
        do_reset();
        launch();
        wait_wb(0, ok);
        ack_delay = 100;
        @(negedge clk);
        total++; if (!ok || state !== 3'd0 || bus.imem_req !== 1'b1 || pc !== 8'd1 || instr_count !== 16'd1)
            $display("FAIL pre_reset got state=%0d req=%0b pc=%0d count=%0d ok=%0b want 0/1/1/1/1",
                     state, bus.imem_req, pc, instr_count, ok);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0 || state !== 3'd6 || pc !== 8'd0 || instr_count !== 16'd0 || bus.imem_addr !== 8'd0)
            $display("FAIL async_reset got req=%0b state=%0d pc=%0d count=%0d addr=%0h want 0/6/0/0/0",
                     bus.imem_req, state, pc, instr_count, bus.imem_addr);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 0;
    endtask

    initial begin
        fill_adds();
        test_reset();
        test_addi_halt();
        test_ack_delay();
        test_branch();
        test_jump_wrap();
        test_invalid();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
